phy_tx_ctrl: RTL
================

Name: phy_tx_ctrl

Overview:
Link controller and arbiter in front of the phy_TX serializer, in the clk_f domain. After reset it sequences link training by emitting COM words. It then shares the single 32-bit TX input between two requesters (src0, src1) using round-robin arbitration with bounded bursts. When no data is granted it fills the link with idle words, and it drives the serializer's active/valid/data_input controls.

Parameters:
DATA_W, 32, word width toward phy_TX (multiple of 8)
TRAIN_WORDS, 4, COM words emitted after reset release (1..255)
MAX_BURST, 4, max words accepted per grant (1..255)
COM_SYM, 8'hBC, training symbol, replicated per byte
IDL_SYM, 8'h7C, idle symbol, replicated per byte

Ports:
clk_f  in  1  single clock (clk_f domain of phy_TX)
reset  in  1  synchronous, active-low reset
src0_valid  in  1  requester 0 has a word
src0_data  in  DATA_W  requester 0 word
src0_ready  out  1  requester 0 word accepted this cycle
src1_valid  in  1  requester 1 has a word
src1_data  in  DATA_W  requester 1 word
src1_ready  out  1  requester 1 word accepted this cycle
tx_active  out  1  drives phy_TX active
tx_valid  out  1  drives phy_TX valid
tx_data  out  DATA_W  drives phy_TX data_input
link_up  out  1  training complete
grant_id  out  1  owner of the current or last burst

Behaviour:
- Reset: reset sampled low at posedge clk_f sets state=RST. tx_active=0, tx_valid=0, tx_data=0, link_up=0, grant_id=0, counters=0, last-grant pointer=1 (src0 wins first tie). srcN_ready=0.
- All tx_* outputs are registered. An accepted word appears on tx_data/tx_valid exactly 1 cycle after the srcN_valid&&srcN_ready cycle.
- srcN_ready is combinational from registered state: high only in DATA with owner==N. It never depends on srcN_valid.
- RST -> TRAIN on the first cycle with reset high.
- TRAIN: tx_active=1, tx_valid=0, tx_data={COM_SYM} replicated. It stays for exactly TRAIN_WORDS cycles, then goes to IDLE and sets link_up=1 (sticky until reset).
- IDLE: tx_active=1, tx_valid=0, tx_data={IDL_SYM} replicated.
  - Arbitrate on src0_valid/src1_valid. If only one requests, it wins. If both request, grant the one not equal to the last-grant pointer.
  - On a winner: register owner, set grant_id, go to DATA, burst_cnt=0.
  - No request: stay in IDLE.
- DATA:
  - Each cycle with owner valid: word accepted, tx_valid=1 next cycle, tx_data=word, burst_cnt++.
  - Cycle with owner valid low: no acceptance; the next-cycle output is an idle word (tx_valid=0). Go to IDLE.
  - When burst_cnt reaches MAX_BURST on an acceptance: go to IDLE and update the last-grant pointer to owner.
  - The last-grant pointer is also updated to owner on any DATA exit after at least one acceptance.
- Fairness: both requesters held valid continuously produces the pattern MAX_BURST words src0, 1 idle, MAX_BURST words src1, 1 idle, repeating.
- The non-owner's ready stays 0 for the whole burst. Its valid/data are held by the source (standard valid/ready).
- Reset mid-burst: the in-flight word is dropped and the block returns to RST next cycle. The srcN_ready drop is immediate upon state=RST.
- Widths: burst_cnt and train_cnt are 8 bits. Compares use parameter values directly; no wrap occurs within legal parameter ranges.

Optional Feature:
Macro PHY_TX_RETRAIN_EN.
- Defined:
  - Adds input retrain_req (1 bit).
  - A pulse is latched into a pending flag. The current DATA burst ends at its next exit point, or immediately if in IDLE.
  - Then: link_up=0, go to TRAIN, emit TRAIN_WORDS COM words, return to IDLE with link_up=1.
  - The pending flag clears on TRAIN entry.
  - retrain_req during TRAIN is ignored.
- Undefined: the port is absent and TRAIN occurs only after reset.

Decomposition:
- Package phy_tx_pkg: state enum (RST, TRAIN, IDLE, DATA), COM_SYM/IDL_SYM defaults, helper for byte replication to DATA_W.
- Sub-module phy_tx_rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], last-grant pointer.
  - Outputs: gnt_valid, gnt_id.
  - Combinational, reused by the top FSM.

Test Plan:
1. Reset low 3 cycles then high, no requests -> 4 cycles tx_data=32'hBCBCBCBC with tx_active=1, tx_valid=0; then link_up=1 and tx_data=32'h7C7C7C7C continuously.
2. src0 only, valid with words 32'hFFFFEEEE, 32'h12345678 -> grant_id=0; words appear on tx_data 1 cycle after acceptance with tx_valid=1; idle word follows when valid drops.
3. Both valid continuously, MAX_BURST=4 -> 4 src0 words, 1 idle, 4 src1 words, 1 idle, repeating; non-owner ready never high.
4. src1 burst in progress, reset low for 1 cycle -> srcN_ready=0 and all outputs 0 next cycle; training restarts with 4 COM words; first post-reset tie goes to src0.
5. src0 drops valid after 2 of 4 words (32'hAAAA1234, 32'hBBBBAAAA) -> DATA exits, 1 idle word is emitted, the pointer updates, and a pending src1 request is granted next.
6. (PHY_TX_RETRAIN_EN) retrain_req pulse mid-burst -> burst finishes, link_up=0, 4 COM words, then IDLE with link_up=1.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// Shared types and helpers for the phy_TX link controller.
package phy_tx_pkg;

  localparam int unsigned SYM_W      = 8;
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned CNT_W      = 8;

  localparam logic [SYM_W-1:0] COM_SYM_DEF = 8'hBC;
  localparam logic [SYM_W-1:0] IDL_SYM_DEF = 8'h7C;

  typedef enum logic [1:0] {
    ST_RST,
    ST_TRAIN,
    ST_IDLE,
    ST_DATA
  } state_t;

  // Replicate one symbol across the widest supported word; callers slice to DATA_W.
  function automatic logic [MAX_DATA_W-1:0] rep_byte(input logic [SYM_W-1:0] b);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(MAX_DATA_W / SYM_W); i++) begin
      r[i*SYM_W +: SYM_W] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/phy_tx_rr_arb2.sv
// Two-requester round-robin arbiter: a tie goes to the requester that did not win last.
module phy_tx_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/phy_tx_ctrl.sv
// Link training sequencer and two-source burst arbiter feeding the phy_TX serializer.
// Optional link retraining on request is enabled with `define PHY_TX_RETRAIN_EN.
module phy_tx_ctrl
  import phy_tx_pkg::*;
#(
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      TRAIN_WORDS = 4,
  parameter int unsigned      MAX_BURST   = 4,
  parameter logic [SYM_W-1:0] COM_SYM     = COM_SYM_DEF,
  parameter logic [SYM_W-1:0] IDL_SYM     = IDL_SYM_DEF
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              src0_valid,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
`ifdef PHY_TX_RETRAIN_EN
  input  logic              retrain_req,
`endif
  output logic              tx_active,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              link_up,
  output logic              grant_id
);

  localparam logic [MAX_DATA_W-1:0] COM_FULL = rep_byte(COM_SYM);
  localparam logic [MAX_DATA_W-1:0] IDL_FULL = rep_byte(IDL_SYM);
  localparam logic [DATA_W-1:0]     COM_WORD = COM_FULL[DATA_W-1:0];
  localparam logic [DATA_W-1:0]     IDL_WORD = IDL_FULL[DATA_W-1:0];
  localparam logic [CNT_W-1:0]      TRAIN_LAST = CNT_W'(TRAIN_WORDS - 1);
  localparam logic [CNT_W-1:0]      BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   train_cnt, train_cnt_d;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_d;
  logic               owner, owner_d;
  logic               last_gnt, last_gnt_d;
  logic               grant_d, link_d, valid_d;
  logic [DATA_W-1:0]  data_d;
  logic               gnt_valid, gnt_id;
  logic               owner_valid;
  logic [DATA_W-1:0]  owner_data;
  logic               retrain_now;

  phy_tx_rr_arb2 u_arb (
    .req       ({src1_valid, src0_valid}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign src0_ready  = (state == ST_DATA) && (owner == 1'b0);
  assign src1_ready  = (state == ST_DATA) && (owner == 1'b1);
  assign owner_valid = owner ? src1_valid : src0_valid;
  assign owner_data  = owner ? src1_data  : src0_data;

`ifdef PHY_TX_RETRAIN_EN
  logic pending, pending_d;

  // A request seen during training is dropped; otherwise it is held until TRAIN entry.
  assign retrain_now = pending | (retrain_req && (state != ST_TRAIN));
  assign pending_d   = retrain_now && (state_d != ST_TRAIN);

  always_ff @(posedge clk_f) begin
    if (!reset) pending <= 1'b0;
    else        pending <= pending_d;
  end
`else
  assign retrain_now = 1'b0;
`endif

  // Next-state, counters and the registered tx word.
  always_comb begin
    state_d     = state;
    train_cnt_d = train_cnt;
    burst_cnt_d = burst_cnt;
    owner_d     = owner;
    last_gnt_d  = last_gnt;
    grant_d     = grant_id;
    link_d      = link_up;
    valid_d     = 1'b0;
    data_d      = IDL_WORD;

    case (state)
      ST_RST: begin
        state_d     = ST_TRAIN;
        train_cnt_d = '0;
      end
      ST_TRAIN: begin
        if (train_cnt == TRAIN_LAST) begin
          state_d = ST_IDLE;
          link_d  = 1'b1;
        end else begin
          train_cnt_d = train_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (retrain_now) begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
          link_d      = 1'b0;
        end else if (gnt_valid) begin
          state_d     = ST_DATA;
          owner_d     = gnt_id;
          grant_d     = gnt_id;
          burst_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (owner_valid) begin
          valid_d     = 1'b1;
          burst_cnt_d = burst_cnt + 1'b1;
          if (burst_cnt == BURST_LAST) begin
            state_d    = ST_IDLE;
            last_gnt_d = owner;
          end
        end else begin
          state_d = ST_IDLE;
          if (burst_cnt != '0) last_gnt_d = owner;
        end
      end
      default: state_d = ST_RST;
    endcase

    if (valid_d)                    data_d = owner_data;
    else if (state_d == ST_TRAIN)   data_d = COM_WORD;
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      state     <= ST_RST;
      train_cnt <= '0;
      burst_cnt <= '0;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      grant_id  <= 1'b0;
      link_up   <= 1'b0;
      tx_active <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state     <= state_d;
      train_cnt <= train_cnt_d;
      burst_cnt <= burst_cnt_d;
      owner     <= owner_d;
      last_gnt  <= last_gnt_d;
      grant_id  <= grant_d;
      link_up   <= link_d;
      tx_active <= 1'b1;
      tx_valid  <= valid_d;
      tx_data   <= data_d;
    end
  end

endmodule
